sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of samples per frame (legal range 2..255).
REQ-002 SHALL have parameter ACC_W, default 8, meaning the accumulator/result width in bits (legal range 3..32).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_sum, input, 3 bits: unsigned sample taken from the upstream 2-bit adder's out[2:0].
REQ-006 SHALL have port in_valid, input, 1 bit: in_sum is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-009 SHALL have port out_total, output, ACC_W bits: frame total, modulo 2^ACC_W.
REQ-010 SHALL have port out_overflow, output, 1 bit: the frame total exceeded 2^ACC_W-1.
REQ-011 SHALL have port out_valid, output, 1 bit: out_total and out_overflow are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-013 SHALL implement a two-state FSM: ACC and DONE.
REQ-014 SHALL drive in_ready=1 in ACC and in_ready=0 in DONE; out_valid=1 only in DONE.
REQ-015 SHALL define an accept as in_valid & in_ready at a rising edge; in_sum is zero-extended to ACC_W before addition.
REQ-016 SHALL, on an accept in ACC with sample count cnt<N-1, set acc<=acc+in_sum (mod 2^ACC_W) and cnt<=cnt+1.
REQ-017 SHALL set a sticky ovf flag when any addition in a frame carries out of bit ACC_W-1.
REQ-018 SHALL, on an accept in ACC with cnt==N-1, latch out_total<=acc+in_sum, latch out_overflow<=ovf|carry, and move to DONE.
REQ-019 SHALL assert out_valid on the cycle after the Nth accept (latency 1).
REQ-020 SHALL hold out_total, out_overflow and out_valid stable in DONE until out_ready=1.
REQ-021 SHALL, on out_ready=1 in DONE, clear acc, cnt and ovf, return to ACC, and drop out_valid on the next cycle.
REQ-022 SHALL NOT accept a sample on the DONE->ACC transition cycle, because in_ready=0 there; the first new accept is possible one cycle later.
REQ-023 SHALL, on clear=1 in ACC, zero acc, cnt and ovf; a simultaneous accepted sample is discarded (clear has priority).
REQ-024 SHALL ignore clear in DONE; a pending result is never lost.
REQ-025 SHALL treat in_valid=0 cycles in ACC as no-ops: state and counters unchanged.
REQ-026 SHALL keep out_total and out_overflow at their last latched values while in ACC; they are meaningful only when out_valid=1.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force state=ACC, acc=0, cnt=0, ovf=0, out_total=0, out_overflow=0 and out_valid=0.
REQ-028 SHALL drive in_ready=1 from the first clock edge after reset_n deasserts.
REQ-029 SHALL discard any partial frame or pending result when reset is asserted mid-operation.

Verification (N=4, ACC_W=8 unless stated)
REQ-030 SHALL pass basic frame: accept 1,2,3,4 on consecutive cycles -> out_valid=1 on the next cycle with out_total=10 and out_overflow=0.
REQ-031 SHALL pass overflow (ACC_W=4): accept 7,7,7,7 -> out_total=12 and out_overflow=1.
REQ-032 SHALL pass backpressure: frame 6,6,6,6 with out_ready=0 for 5 cycles -> out_valid=1, out_total=24 and in_ready=0 held for all 5 cycles, then one handshake, then in_ready=1 one cycle later.
REQ-033 SHALL pass gaps and clear: accept 5, 5, then idle for 2 cycles, then clear=1 with in_valid=1 and in_sum=7, then accept 1,1,1,1 -> out_total=4.
REQ-034 SHALL pass reset mid-frame: accept 3,3 then pulse reset_n low between edges -> all outputs 0 immediately; accepting 2,2,2,2 afterwards gives out_total=8.
REQ-035 SHALL pass back-to-back frames: 4,4,4,4 and 1,0,0,1 with out_ready=1 throughout -> totals 16 then 2, with a one-cycle in_ready=0 gap between frames.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums N 3-bit samples into an ACC_W-bit total.
// Holds the result with a sticky overflow flag until downstream takes it.
module sum_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       in_sum,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    S_ACC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_ovf;
  logic             w_ovf_nx;
  logic [ACC_W-1:0] r_total;
  logic [ACC_W-1:0] w_total_nx;
  logic             r_ovf_out;
  logic             w_ovf_out_nx;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  // Extra top bit captures the carry out of the running sum.
  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(in_sum);
  assign w_carry = w_sum[ACC_W];

  assign out_total    = r_total;
  assign out_overflow = r_ovf_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_total   <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_acc     <= w_acc_nx;
      r_cnt     <= w_cnt_nx;
      r_ovf     <= w_ovf_nx;
      r_total   <= w_total_nx;
      r_ovf_out <= w_ovf_out_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_acc_nx     = r_acc;
    w_cnt_nx     = r_cnt;
    w_ovf_nx     = r_ovf;
    w_total_nx   = r_total;
    w_ovf_out_nx = r_ovf_out;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        if (clear) begin
          w_acc_nx = '0;
          w_cnt_nx = '0;
          w_ovf_nx = 1'b0;
        end else if (in_valid) begin
          if (r_cnt == LAST) begin
            w_total_nx   = w_sum[ACC_W-1:0];
            w_ovf_out_nx = r_ovf | w_carry;
            w_state_nx   = S_DONE;
          end else begin
            w_acc_nx = w_sum[ACC_W-1:0];
            w_cnt_nx = r_cnt + CNT_W'(1);
            w_ovf_nx = r_ovf | w_carry;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_acc_nx   = '0;
          w_cnt_nx   = '0;
          w_ovf_nx   = 1'b0;
          w_state_nx = S_ACC;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two widths (8 and 4 bits) share one stimulus,
// checked every cycle against an integer frame-sum model.
module tb_sum_accumulator;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] in_sum = '0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy8, rdy4, val8, val4, ovf8, ovf4;
  logic [7:0] tot8;
  logic [3:0] tot4;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  bit m_done = 1'b0;
  int m_sum  = 0;
  int m_cnt  = 0;
  int m_lt   = 0;

  always #5 clock = ~clock;

  sum_accumulator #(.N(N), .ACC_W(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n),
    .in_sum(in_sum), .in_valid(in_valid), .in_ready(rdy8),
    .clear(clear),
    .out_total(tot8), .out_overflow(ovf8),
    .out_valid(val8), .out_ready(out_ready)
  );

  sum_accumulator #(.N(N), .ACC_W(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n),
    .in_sum(in_sum), .in_valid(in_valid), .in_ready(rdy4),
    .clear(clear),
    .out_total(tot4), .out_overflow(ovf4),
    .out_valid(val4), .out_ready(out_ready)
  );

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Frame model: true integer sum; total and overflow derive from it.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_done = 1'b0;
      m_sum  = 0;
      m_cnt  = 0;
      m_lt   = 0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
      end
    end else if (clear) begin
      m_sum = 0;
      m_cnt = 0;
    end else if (in_valid) begin
      m_sum += int'(in_sum);
      m_cnt++;
      if (m_cnt == N) begin
        m_lt   = m_sum;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready8", int'(rdy8), int'(!m_done));
      chk("in_ready4", int'(rdy4), int'(!m_done));
      chk("out_valid8", int'(val8), int'(m_done));
      chk("out_valid4", int'(val4), int'(m_done));
      chk("total8", int'(tot8), m_lt % 256);
      chk("total4", int'(tot4), m_lt % 16);
      chk("ovf8", int'(ovf8), int'(m_lt > 255));
      chk("ovf4", int'(ovf4), int'(m_lt > 15));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(int v);
    int k = 0;
    in_sum   = 3'(v);
    in_valid = 1'b1;
    while (!rdy8 && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    step();
    chk_en = 1'b1;
    chk("rst_valid", int'(val8), 0);
    chk("rst_ready", int'(rdy8), 1);
    chk("rst_total", int'(tot8), 0);

    // Basic frame
    send(1); send(2); send(3); send(4);
    chk("basic_valid", int'(val8), 1);
    chk("basic_total", int'(tot8), 10);
    chk("basic_ovf", int'(ovf8), 0);
    handshake();
    chk("basic_drop", int'(val8), 0);
    step();

    // Overflow on the narrow instance
    send(7); send(7); send(7); send(7);
    chk("ovf4_total", int'(tot4), 12);
    chk("ovf4_flag", int'(ovf4), 1);
    chk("ovf8_total", int'(tot8), 28);
    chk("ovf8_flag", int'(ovf8), 0);
    handshake();
    step();

    // Backpressure: result and stall hold for 5 cycles
    send(6); send(6); send(6); send(6);
    in_valid = 1'b1;
    in_sum   = 3'd5;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(val8), 1);
      chk("bp_total", int'(tot8), 24);
      chk("bp_ready", int'(rdy8), 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_hs_ready", int'(rdy8), 0);
    step();
    out_ready = 1'b0;
    chk("bp_after", int'(rdy8), 1);
    chk("bp_after_v", int'(val8), 0);
    step();

    // Gaps then clear with a discarded sample
    send(5); send(5);
    step(); step();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 3'd7;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    send(1); send(1); send(1); send(1);
    chk("clear_total", int'(tot8), 4);
    handshake();
    step();

    // Reset between edges mid-frame
    send(3); send(3);
    reset_n = 1'b0;
    #2;
    chk("mrst_valid", int'(val8), 0);
    chk("mrst_total", int'(tot8), 0);
    chk("mrst_ovf4", int'(ovf4), 0);
    #1;
    reset_n = 1'b1;
    step();
    send(2); send(2); send(2); send(2);
    chk("mrst_frame", int'(tot8), 8);
    handshake();
    step();

    // Back-to-back frames, downstream always ready
    out_ready = 1'b1;
    send(4); send(4); send(4); send(4);
    chk("b2b_t1", int'(tot8), 16);
    chk("b2b_gap", int'(rdy8), 0);
    send(1); send(0); send(0); send(1);
    chk("b2b_t2", int'(tot8), 2);
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sum    = 3'($urandom);
      clear     = ($urandom % 16) == 0;
      out_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
